// File: rtl/board_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// Holds the mark/state enums, the eight win lines and the line/full evaluators.
package board_pkg;

  localparam int unsigned NUM_CELLS = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } mark_t;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_CHECK,
    ST_WIN,
    ST_DRAW
  } state_t;

  typedef logic [NUM_CELLS-1:0][1:0] board_t;

  // Rows, columns, then the two diagonals; indices are row-major from top-left.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic mark_t check_win(input board_t b);
    mark_t w;
    w = EMPTY;
    for (int i = 0; i < 8; i++) begin
      if (b[WIN_LINES[i][0]] != EMPTY &&
          b[WIN_LINES[i][0]] == b[WIN_LINES[i][1]] &&
          b[WIN_LINES[i][0]] == b[WIN_LINES[i][2]]) begin
        w = mark_t'(b[WIN_LINES[i][0]]);
      end
    end
    return w;
  endfunction

  function automatic logic board_full(input board_t b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (b[i] == EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/key_edge.sv
// One-register rising-edge detector for a debounced, active-high key.
// rise is high for the single cycle in which the key is high but was low last cycle.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = key;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = key & ~prev_q;

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: cursor, placement, one-cycle win/draw check, restart.
// Define BOARD_SCORE_EN to add saturating per-mark win counters (score_x/score_o).
module board_controller
  import board_pkg::*;
#(
  parameter logic [1:0] FIRST_MARK = 2'b01
`ifdef BOARD_SCORE_EN
  , parameter int unsigned SCORE_W = 4
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_place,
  input  logic            key_restart,
  output logic [3:0]      currentCell,
  output logic [8:0][1:0] currentGame,
  output logic [1:0]      turn,
  output logic [1:0]      winner,
  output logic            game_over
`ifdef BOARD_SCORE_EN
  , output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o
`endif
);

  // Bit order sets priority: restart, place, up, down, left, right.
  logic [5:0] key_vec, rise_vec;
  assign key_vec = {key_restart, key_place, key_up, key_down, key_left, key_right};

  for (genvar g = 0; g < 6; g++) begin : g_edge
    key_edge u_edge (.clk(clk), .reset(reset), .key(key_vec[g]), .rise(rise_vec[g]));
  end

  state_t     state_q, state_d;
  board_t     board_q, board_d;
  logic [3:0] cell_q, cell_d;
  mark_t      turn_q, turn_d;
  logic [1:0] winner_q, winner_d;
  logic       restart_pend_q, restart_pend_d;
  mark_t      line_mark;

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves one unassigned (no latch).
    state_d        = state_q;
    board_d        = board_q;
    cell_d         = cell_q;
    turn_d         = turn_q;
    winner_d       = winner_q;
    restart_pend_d = restart_pend_q;
    line_mark      = check_win(board_q);

    case (state_q)
      ST_CHECK: begin
        // A restart seen here is held until the check has resolved.
        if (rise_vec[5]) restart_pend_d = 1'b1;
        if (line_mark != EMPTY) begin
          state_d  = ST_WIN;
          winner_d = line_mark;
        end else if (board_full(board_q)) begin
          state_d  = ST_DRAW;
          winner_d = 2'b11;
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        if (rise_vec[5] || restart_pend_q) begin
          state_d        = ST_PLAY;
          board_d        = '0;
          cell_d         = 4'd0;
          turn_d         = mark_t'(FIRST_MARK);
          winner_d       = 2'b00;
          restart_pend_d = 1'b0;
        end else if (state_q == ST_PLAY) begin
          if (rise_vec[4]) begin
            if (board_q[cell_q] == EMPTY) begin
              board_d[cell_q] = turn_q;
              turn_d          = (turn_q == X) ? O : X;
              state_d         = ST_CHECK;
            end
          end else if (rise_vec[3]) begin
            cell_d = (cell_q >= 4'd3) ? cell_q - 4'd3 : cell_q + 4'd6;
          end else if (rise_vec[2]) begin
            cell_d = (cell_q < 4'd6) ? cell_q + 4'd3 : cell_q - 4'd6;
          end else if (rise_vec[1]) begin
            cell_d = (cell_q % 4'd3 == 4'd0) ? cell_q + 4'd2 : cell_q - 4'd1;
          end else if (rise_vec[0]) begin
            cell_d = (cell_q % 4'd3 == 4'd2) ? cell_q - 4'd2 : cell_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_PLAY;
      board_q        <= '0;
      cell_q         <= 4'd0;
      turn_q         <= mark_t'(FIRST_MARK);
      winner_q       <= 2'b00;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      cell_q         <= cell_d;
      turn_q         <= turn_d;
      winner_q       <= winner_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign currentCell = cell_q;
  assign currentGame = board_q;
  assign turn        = turn_q;
  assign winner      = winner_q;
  assign game_over   = (state_q == ST_WIN) || (state_q == ST_DRAW);

`ifdef BOARD_SCORE_EN
  logic [SCORE_W-1:0] score_x_q, score_x_d, score_o_q, score_o_d;

  // Counters survive restart; only reset clears them.
  always_comb begin
    score_x_d = score_x_q;
    score_o_d = score_o_q;
    if (state_q == ST_CHECK && state_d == ST_WIN) begin
      if (winner_d == X && score_x_q != '1) score_x_d = score_x_q + SCORE_W'(1);
      if (winner_d == O && score_o_q != '1) score_o_d = score_o_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_x_q <= '0;
      score_o_q <= '0;
    end else begin
      score_x_q <= score_x_d;
      score_o_q <= score_o_d;
    end
  end

  assign score_x = score_x_q;
  assign score_o = score_o_q;
`endif

endmodule

// File: tb/tb_board_controller.sv
// Directed self-checking bench for board_controller: cursor, placement, win/draw,
// key priority, deferred restart, reset priority and (with BOARD_SCORE_EN) score saturation.
module tb_board_controller;

  localparam logic [5:0] K_RIGHT   = 6'b000001;
  localparam logic [5:0] K_LEFT    = 6'b000010;
  localparam logic [5:0] K_DOWN    = 6'b000100;
  localparam logic [5:0] K_UP      = 6'b001000;
  localparam logic [5:0] K_PLACE   = 6'b010000;
  localparam logic [5:0] K_RESTART = 6'b100000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [5:0]      keys = '0;
  logic [3:0]      currentCell;
  logic [8:0][1:0] currentGame;
  logic [1:0]      turn, winner;
  logic            game_over;
`ifdef BOARD_SCORE_EN
  logic [3:0]      score_x, score_o;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int cur     = 0;

  always #5 clk = ~clk;

  board_controller dut (
    .clk(clk), .reset(reset),
    .key_up(keys[3]), .key_down(keys[2]), .key_left(keys[1]), .key_right(keys[0]),
    .key_place(keys[4]), .key_restart(keys[5]),
    .currentCell(currentCell), .currentGame(currentGame),
    .turn(turn), .winner(winner), .game_over(game_over)
`ifdef BOARD_SCORE_EN
    , .score_x(score_x), .score_o(score_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the keys for one edge, then hold them low for one edge so the next press is seen.
  task automatic press(input logic [5:0] mask);
    keys = mask;
    tick();
    keys = '0;
    tick();
  endtask

  task automatic do_reset();
    keys  = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cur   = 0;
  endtask

  task automatic goto_cell(input int t);
    int r, d;
    r = (t % 3 - cur % 3 + 3) % 3;
    d = (t / 3 - cur / 3 + 3) % 3;
    for (int i = 0; i < r; i++) press(K_RIGHT);
    for (int i = 0; i < d; i++) press(K_DOWN);
    cur = t;
  endtask

  task automatic place_at(input int t);
    goto_cell(t);
    press(K_PLACE);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (currentCell !== 4'd0) $display("FAIL reset_cell: got %0d expected 0", currentCell); else n_pass++;
    n_total++; if (currentGame !== '0) $display("FAIL reset_board: got %h expected 0", currentGame); else n_pass++;
    n_total++; if (turn !== 2'b01) $display("FAIL reset_turn: got %b expected 01", turn); else n_pass++;
    n_total++; if (winner !== 2'b00 || game_over !== 1'b0)
      $display("FAIL reset_winner: got %b/%b expected 00/0", winner, game_over); else n_pass++;
  endtask

  task automatic test_cursor();
    do_reset();
    press(K_RIGHT); press(K_RIGHT); press(K_DOWN);
    n_total++; if (currentCell !== 4'd5) $display("FAIL cursor_r_r_d: got %0d expected 5", currentCell); else n_pass++;
    press(K_RIGHT);
    n_total++; if (currentCell !== 4'd3) $display("FAIL cursor_wrap_right: got %0d expected 3", currentCell); else n_pass++;
    press(K_LEFT);
    n_total++; if (currentCell !== 4'd5) $display("FAIL cursor_wrap_left: got %0d expected 5", currentCell); else n_pass++;
    press(K_UP); press(K_UP);
    n_total++; if (currentCell !== 4'd8) $display("FAIL cursor_wrap_up: got %0d expected 8", currentCell); else n_pass++;
    press(K_DOWN);
    n_total++; if (currentCell !== 4'd2) $display("FAIL cursor_wrap_down: got %0d expected 2", currentCell); else n_pass++;
    keys = K_LEFT; tick(); tick(); tick(); keys = '0; tick();
    n_total++; if (currentCell !== 4'd1) $display("FAIL cursor_held_key: got %0d expected 1", currentCell); else n_pass++;
  endtask

  task automatic test_win();
    logic [8:0][1:0] exp;
    do_reset();
    place_at(0); place_at(3); place_at(1); place_at(4);
    goto_cell(2);
    keys = K_PLACE; tick(); keys = '0;
    n_total++; if (currentGame[2] !== 2'b01 || game_over !== 1'b0 || winner !== 2'b00)
      $display("FAIL win_edge_k: got cell2=%b over=%b win=%b expected 01/0/00", currentGame[2], game_over, winner); else n_pass++;
    tick();
    exp = '0;
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b10; exp[4] = 2'b10;
    n_total++; if (currentGame !== exp) $display("FAIL win_board: got %h expected %h", currentGame, exp); else n_pass++;
    n_total++; if (winner !== 2'b01 || game_over !== 1'b1)
      $display("FAIL win_edge_k1: got win=%b over=%b expected 01/1", winner, game_over); else n_pass++;
    press(K_DOWN);
    n_total++; if (currentCell !== 4'd2) $display("FAIL win_cursor_hold: got %0d expected 2", currentCell); else n_pass++;
    press(K_RESTART); cur = 0;
    n_total++; if (currentGame !== '0 || winner !== 2'b00 || game_over !== 1'b0 || turn !== 2'b01 || currentCell !== 4'd0)
      $display("FAIL win_restart: got board=%h win=%b over=%b turn=%b cell=%0d expected 0/00/0/01/0",
               currentGame, winner, game_over, turn, currentCell); else n_pass++;
  endtask

  task automatic test_occupied();
    do_reset();
    place_at(4);
    n_total++; if (currentGame[4] !== 2'b01 || turn !== 2'b10)
      $display("FAIL occ_first: got cell4=%b turn=%b expected 01/10", currentGame[4], turn); else n_pass++;
    press(K_PLACE);
    n_total++; if (currentGame[4] !== 2'b01 || turn !== 2'b10 || game_over !== 1'b0)
      $display("FAIL occ_second: got cell4=%b turn=%b over=%b expected 01/10/0", currentGame[4], turn, game_over); else n_pass++;
    press(K_RIGHT);
    n_total++; if (currentCell !== 4'd5) $display("FAIL occ_still_play: got %0d expected 5", currentCell); else n_pass++;
  endtask

  task automatic test_draw();
    logic [8:0][1:0] exp;
    do_reset();
    place_at(0); place_at(1); place_at(2); place_at(4); place_at(3);
    place_at(5); place_at(7); place_at(6); place_at(8);
    exp = {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    n_total++; if (currentGame !== exp) $display("FAIL draw_board: got %h expected %h", currentGame, exp); else n_pass++;
    n_total++; if (winner !== 2'b11 || game_over !== 1'b1)
      $display("FAIL draw_result: got win=%b over=%b expected 11/1", winner, game_over); else n_pass++;
    press(K_PLACE); press(K_LEFT);
    n_total++; if (currentGame !== exp || currentCell !== 4'd8 || winner !== 2'b11)
      $display("FAIL draw_frozen: got board=%h cell=%0d win=%b expected %h/8/11", currentGame, currentCell, winner, exp); else n_pass++;
  endtask

  task automatic test_priority_restart();
    do_reset();
    press(K_PLACE | K_UP);
    n_total++; if (currentGame[0] !== 2'b01 || currentCell !== 4'd0)
      $display("FAIL prio_place_up: got cell0=%b cell=%0d expected 01/0", currentGame[0], currentCell); else n_pass++;
    press(K_RIGHT);
    keys = K_PLACE; tick();
    keys = K_RESTART; tick();
    n_total++; if (currentGame[0] !== 2'b01 || currentGame[1] !== 2'b10)
      $display("FAIL restart_in_check: got cell0=%b cell1=%b expected 01/10", currentGame[0], currentGame[1]); else n_pass++;
    keys = '0; tick();
    n_total++; if (currentGame !== '0 || currentCell !== 4'd0 || turn !== 2'b01 || winner !== 2'b00)
      $display("FAIL restart_deferred: got board=%h cell=%0d turn=%b win=%b expected 0/0/01/00",
               currentGame, currentCell, turn, winner); else n_pass++;
  endtask

  task automatic test_reset_priority();
    do_reset();
    press(K_RIGHT);
    keys = K_PLACE; tick();
    reset = 1'b1; keys = K_RESTART | K_DOWN; tick();
    reset = 1'b0; keys = '0; cur = 0;
    n_total++; if (currentGame !== '0 || currentCell !== 4'd0 || turn !== 2'b01 || game_over !== 1'b0)
      $display("FAIL reset_in_check: got board=%h cell=%0d turn=%b over=%b expected 0/0/01/0",
               currentGame, currentCell, turn, game_over); else n_pass++;
    tick();
    n_total++; if (currentCell !== 4'd0 || currentGame !== '0)
      $display("FAIL reset_kills_keys: got cell=%0d board=%h expected 0/0", currentCell, currentGame); else n_pass++;
  endtask

`ifdef BOARD_SCORE_EN
  task automatic test_score();
    int exp_x;
    do_reset();
    for (int g = 0; g < 16; g++) begin
      place_at(0); place_at(3); place_at(1); place_at(4); place_at(2);
      exp_x = (g + 1 > 15) ? 15 : g + 1;
      n_total++; if (score_x !== 4'(exp_x) || score_o !== 4'd0)
        $display("FAIL score_win%0d: got x=%0d o=%0d expected %0d/0", g, score_x, score_o, exp_x); else n_pass++;
      press(K_RESTART); cur = 0;
    end
    do_reset();
    n_total++; if (score_x !== 4'd0) $display("FAIL score_reset: got %0d expected 0", score_x); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_cursor();
    test_win();
    test_occupied();
    test_draw();
    test_priority_restart();
    test_reset_priority();
`ifdef BOARD_SCORE_EN
    test_score();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
